// File: rtl/pillar_wb_pkg.sv
// rtl/pillar_wb_pkg.sv - shared write-back widths, source and occupancy enums
package pillar_wb_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_BOTH  = 2'd2
  } occ_e;

endpackage

// File: rtl/wb_hold_entry.sv
// rtl/wb_hold_entry.sv - one write-back holding entry (valid, rd, data, age)
module wb_hold_entry
  import pillar_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic              i_age_clr,
  input  logic              i_age,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [REG_AW-1:0] o_rd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_age
);

  logic              r_valid;
  logic              r_age;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_data;

  // A load in the same cycle as a clear is a refill after a grant, so load wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_age   <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_age   <= i_age;
      r_rd    <= i_rd;
      r_data  <= i_data;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_age   <= 1'b0;
    end else if (i_age_clr) begin
      r_age   <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_rd    = r_rd;
  assign o_data  = r_data;
  assign o_age   = r_age;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - ALU/memory write-back arbiter onto one register-file write port.
// Define WB_BYPASS_EN to grant an offer in its acceptance cycle when both entries are empty.
module wb_arbiter
  import pillar_wb_pkg::*;
#(
  parameter int MEM_PRIO     = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid_i,
  input  logic [REG_AW-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              mem_valid_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              mem_ready_o,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              stall_o
);

  localparam int            SW         = (STARVE_LIMIT < 3) ? 2 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic              w_alu_v, w_mem_v;
  logic              w_alu_age, w_mem_age;
  logic [REG_AW-1:0] w_alu_rd, w_mem_rd;
  logic [DATA_W-1:0] w_alu_data, w_mem_data;
  logic [SW-1:0]     r_alu_starve, r_mem_starve;
  logic              w_grant_any, w_alu_grant, w_mem_grant;
  src_e              w_grant_src, w_pref_src;
  occ_e              w_occ;
  logic              w_byp_alu, w_byp_mem;
  logic              w_alu_load, w_mem_load;
  logic              w_wr_go;
  logic [REG_AW-1:0] w_wr_rd;
  logic [DATA_W-1:0] w_wr_data;
  logic              r_we;
  logic [REG_AW-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  always_comb begin
    w_occ = OCC_ONE;
    case ({w_alu_v, w_mem_v})
      2'b00:   w_occ = OCC_EMPTY;
      2'b11:   w_occ = OCC_BOTH;
      default: w_occ = OCC_ONE;
    endcase
  end

  // Same rd keeps program order via the age bits; otherwise priority with starvation override.
  always_comb begin
    w_pref_src  = (MEM_PRIO != 0) ? SRC_MEM : SRC_ALU;
    w_grant_any = w_alu_v | w_mem_v;
    w_grant_src = w_pref_src;
    if (w_alu_v && !w_mem_v) begin
      w_grant_src = SRC_ALU;
    end else if (!w_alu_v && w_mem_v) begin
      w_grant_src = SRC_MEM;
    end else if (w_alu_v && w_mem_v) begin
      if (w_alu_rd == w_mem_rd) begin
        if (w_alu_age != w_mem_age)
          w_grant_src = w_alu_age ? SRC_MEM : SRC_ALU;
      end else if (w_pref_src == SRC_MEM) begin
        if (r_alu_starve == STARVE_MAX) w_grant_src = SRC_ALU;
      end else begin
        if (r_mem_starve == STARVE_MAX) w_grant_src = SRC_MEM;
      end
    end
  end

  assign w_alu_grant = w_grant_any && (w_grant_src == SRC_ALU);
  assign w_mem_grant = w_grant_any && (w_grant_src == SRC_MEM);

`ifdef WB_BYPASS_EN
  always_comb begin
    w_byp_alu = 1'b0;
    w_byp_mem = 1'b0;
    if (!reset && (w_occ == OCC_EMPTY)) begin
      if (alu_valid_i && mem_valid_i) begin
        w_byp_mem = (MEM_PRIO != 0);
        w_byp_alu = (MEM_PRIO == 0);
      end else begin
        w_byp_alu = alu_valid_i;
        w_byp_mem = mem_valid_i;
      end
    end
  end
`else
  assign w_byp_alu = 1'b0;
  assign w_byp_mem = 1'b0;
`endif

  assign alu_ready_o = !reset && (!w_alu_v || w_alu_grant);
  assign mem_ready_o = !reset && (!w_mem_v || w_mem_grant);
  assign w_alu_load  = alu_valid_i && alu_ready_o && !w_byp_alu;
  assign w_mem_load  = mem_valid_i && mem_ready_o && !w_byp_mem;

  wb_hold_entry u_alu_entry (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_alu_load),
    .i_clear   (w_alu_grant),
    .i_age_clr (w_mem_grant),
    .i_age     (w_mem_v && !w_mem_grant),
    .i_rd      (alu_rd_i),
    .i_data    (alu_data_i),
    .o_valid   (w_alu_v),
    .o_rd      (w_alu_rd),
    .o_data    (w_alu_data),
    .o_age     (w_alu_age)
  );

  wb_hold_entry u_mem_entry (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_mem_load),
    .i_clear   (w_mem_grant),
    .i_age_clr (w_alu_grant),
    .i_age     (w_alu_v && !w_alu_grant),
    .i_rd      (mem_rd_i),
    .i_data    (mem_data_i),
    .o_valid   (w_mem_v),
    .o_rd      (w_mem_rd),
    .o_data    (w_mem_data),
    .o_age     (w_mem_age)
  );

  always_comb begin
    w_wr_go   = 1'b0;
    w_wr_rd   = w_alu_rd;
    w_wr_data = w_alu_data;
    if (w_byp_alu) begin
      w_wr_go   = 1'b1;
      w_wr_rd   = alu_rd_i;
      w_wr_data = alu_data_i;
    end else if (w_byp_mem) begin
      w_wr_go   = 1'b1;
      w_wr_rd   = mem_rd_i;
      w_wr_data = mem_data_i;
    end else if (w_grant_any) begin
      w_wr_go = 1'b1;
      if (w_grant_src == SRC_MEM) begin
        w_wr_rd   = w_mem_rd;
        w_wr_data = w_mem_data;
      end
    end
  end

  // A grant of rd 0 still retires the entry but never reaches the register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_wr_go && (w_wr_rd != '0);
      if (w_wr_go && (w_wr_rd != '0)) begin
        r_waddr <= w_wr_rd;
        r_wdata <= w_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alu_starve <= '0;
      r_mem_starve <= '0;
    end else begin
      if (!w_alu_v || w_alu_grant)
        r_alu_starve <= '0;
      else if (w_mem_grant && (r_alu_starve != '1))
        r_alu_starve <= r_alu_starve + 1'b1;
      if (!w_mem_v || w_mem_grant)
        r_mem_starve <= '0;
      else if (w_alu_grant && (r_mem_starve != '1))
        r_mem_starve <= r_mem_starve + 1'b1;
    end
  end

  assign rf_we_o    = r_we;
  assign rf_waddr_o = r_waddr;
  assign rf_wdata_o = r_wdata;
  assign stall_o    = (w_occ == OCC_BOTH);

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - wb_arbiter bench: directed scenarios plus random traffic vs a behavioural model
module tb_wb_arbiter;
  import pillar_wb_pkg::*;

  localparam int MEM_PRIO     = 1;
  localparam int STARVE_LIMIT = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid_i, mem_valid_i;
  logic [REG_AW-1:0] alu_rd_i, mem_rd_i;
  logic [DATA_W-1:0] alu_data_i, mem_data_i;
  logic              alu_ready_o, mem_ready_o;
  logic              rf_we_o, stall_o;
  logic [REG_AW-1:0] rf_waddr_o;
  logic [DATA_W-1:0] rf_wdata_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.MEM_PRIO(MEM_PRIO), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i), .alu_ready_o(alu_ready_o),
    .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i), .mem_data_i(mem_data_i), .mem_ready_o(mem_ready_o),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .stall_o(stall_o)
  );

  // Model: index 0 = ALU, 1 = MEM; stamp is the edge number an entry was accepted on.
  bit                m_v      [2];
  logic [REG_AW-1:0] m_rd     [2];
  logic [DATA_W-1:0] m_data   [2];
  int                m_stamp  [2];
  int                m_starve [2];
  int                edge_no = 0;
  logic              exp_we;
  logic [REG_AW-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;

  function automatic int m_winner();
    int pref;
    pref = (MEM_PRIO != 0) ? 1 : 0;
    if (m_v[0] && m_v[1]) begin
      if (m_rd[0] == m_rd[1]) begin
        if (m_stamp[0] != m_stamp[1]) return (m_stamp[0] < m_stamp[1]) ? 0 : 1;
        return pref;
      end
      if (m_starve[1 - pref] == STARVE_LIMIT) return 1 - pref;
      return pref;
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction

  function automatic bit m_ready(int s);
    return !reset && (!m_v[s] || (m_winner() == s));
  endfunction

  task automatic model_edge();
    int                w;
    bit                acc   [2];
    bit                in_v  [2];
    logic [REG_AW-1:0] in_rd [2];
    logic [DATA_W-1:0] in_dat[2];
    bit                was_empty;
    in_v[0] = alu_valid_i; in_rd[0] = alu_rd_i; in_dat[0] = alu_data_i;
    in_v[1] = mem_valid_i; in_rd[1] = mem_rd_i; in_dat[1] = mem_data_i;
    edge_no++;
    if (reset) begin
      for (int s = 0; s < 2; s++) begin m_v[s] = 0; m_starve[s] = 0; end
      exp_we = 0; exp_addr = '0; exp_data = '0;
      return;
    end
    w = m_winner();
    was_empty = !m_v[0] && !m_v[1];
    for (int s = 0; s < 2; s++) acc[s] = in_v[s] && (!m_v[s] || (w == s));
    exp_we = 0;
    if (w >= 0) begin
      if (m_rd[w] != 0) begin exp_we = 1; exp_addr = m_rd[w]; exp_data = m_data[w]; end
      for (int s = 0; s < 2; s++)
        if (m_v[s] && s != w) m_starve[s]++; else m_starve[s] = 0;
      m_v[w] = 0;
    end
`ifdef WB_BYPASS_EN
    if (was_empty && (acc[0] || acc[1])) begin
      int b;
      b = (acc[0] && acc[1]) ? ((MEM_PRIO != 0) ? 1 : 0) : (acc[1] ? 1 : 0);
      if (in_rd[b] != 0) begin exp_we = 1; exp_addr = in_rd[b]; exp_data = in_dat[b]; end
      acc[b] = 0;
    end
`endif
    for (int s = 0; s < 2; s++)
      if (acc[s]) begin
        m_v[s] = 1; m_rd[s] = in_rd[s]; m_data[s] = in_dat[s]; m_stamp[s] = edge_no; m_starve[s] = 0;
      end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input bit v, input int rd, input logic [31:0] d);
    alu_valid_i = v; alu_rd_i = REG_AW'(rd); alu_data_i = d;
  endtask

  task automatic set_mem(input bit v, input int rd, input logic [31:0] d);
    mem_valid_i = v; mem_rd_i = REG_AW'(rd); mem_data_i = d;
  endtask

  task automatic do_reset();
    reset = 1; set_alu(0, 0, 0); set_mem(0, 0, 0);
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; set_alu(1, 9, 32'h1234); set_mem(1, 8, 32'h5678);
    tick(); tick();
    set_alu(0, 0, 0); set_mem(0, 0, 0);
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", rf_we_o); end
    checks++; if (rf_waddr_o !== 5'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", rf_waddr_o); end
    checks++; if (rf_wdata_o !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %0h expected 0", rf_wdata_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall_o); end
    checks++; if ({alu_ready_o, mem_ready_o} !== 2'b00) begin errors++; $display("FAIL reset_ready_gated: got %b expected 00", {alu_ready_o, mem_ready_o}); end
    reset = 0; #1;
    checks++; if ({alu_ready_o, mem_ready_o} !== 2'b11) begin errors++; $display("FAIL reset_ready_release: got %b expected 11", {alu_ready_o, mem_ready_o}); end
  endtask

`ifndef WB_BYPASS_EN
  task automatic test_single_alu();
    do_reset();
    set_alu(1, 5, 32'hAA); tick(); set_alu(0, 0, 0);
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL single_we_early: got %0b expected 0", rf_we_o); end
    tick();
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd5, 32'hAA}) begin
      errors++; $display("FAIL single_write: got we=%0b rd=%0d data=%0h expected we=1 rd=5 data=aa", rf_we_o, rf_waddr_o, rf_wdata_o); end
    tick();
    checks++; if ({rf_we_o, rf_waddr_o} !== {1'b0, 5'd5}) begin
      errors++; $display("FAIL single_hold: got we=%0b rd=%0d expected we=0 rd=5", rf_we_o, rf_waddr_o); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_alu(1, 3, 32'h11); set_mem(1, 4, 32'h22); tick(); set_alu(0, 0, 0); set_mem(0, 0, 0);
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL pair_stall: got %0b expected 1", stall_o); end
    tick();
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o, stall_o} !== {1'b1, 5'd4, 32'h22, 1'b0}) begin
      errors++; $display("FAIL pair_first: got we=%0b rd=%0d data=%0h stall=%0b expected 1/4/22/0", rf_we_o, rf_waddr_o, rf_wdata_o, stall_o); end
    tick();
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'h11}) begin
      errors++; $display("FAIL pair_second: got we=%0b rd=%0d data=%0h expected 1/3/11", rf_we_o, rf_waddr_o, rf_wdata_o); end
    tick();
    checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL pair_idle: got %0b expected 0", rf_we_o); end
  endtask

  task automatic test_starve();
    int k;
    do_reset();
    k = 0;
    set_alu(1, 1, 32'h100); set_mem(1, 2, 32'h200); tick(); set_alu(0, 0, 0);
    for (int i = 1; i <= 8 && k == 0; i++) begin
      set_mem(1, 2 + i, 32'h200 + i);
      tick();
      if (rf_we_o === 1'b1 && rf_waddr_o === 5'd1) k = i;
      else if (i < 4) begin
        checks++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'(1 + i)}) begin
          errors++; $display("FAIL starve_mem_order: got we=%0b rd=%0d expected we=1 rd=%0d", rf_we_o, rf_waddr_o, 1 + i); end
      end
    end
    set_mem(0, 0, 0);
    checks++; if (k != 4) begin errors++; $display("FAIL starve_alu_grant: got cycle %0d expected 4", k); end
  endtask

  task automatic test_age();
    do_reset();
    set_alu(1, 6, 32'hA6); set_mem(1, 7, 32'hB7); tick();
    set_alu(0, 0, 0); set_mem(1, 6, 32'hB6); tick(); set_mem(0, 0, 0);
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'hB7}) begin
      errors++; $display("FAIL age_first: got we=%0b rd=%0d data=%0h expected 1/7/b7", rf_we_o, rf_waddr_o, rf_wdata_o); end
    tick();
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd6, 32'hA6}) begin
      errors++; $display("FAIL age_older: got we=%0b rd=%0d data=%0h expected 1/6/a6", rf_we_o, rf_waddr_o, rf_wdata_o); end
    tick();
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd6, 32'hB6}) begin
      errors++; $display("FAIL age_younger: got we=%0b rd=%0d data=%0h expected 1/6/b6", rf_we_o, rf_waddr_o, rf_wdata_o); end
  endtask
`else
  task automatic test_bypass();
    do_reset();
    set_alu(1, 7, 32'h55); tick(); set_alu(0, 0, 0);
    checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd7, 32'h55}) begin
      errors++; $display("FAIL bypass_write: got we=%0b rd=%0d data=%0h expected 1/7/55", rf_we_o, rf_waddr_o, rf_wdata_o); end
  endtask
`endif

  task automatic test_drop();
    do_reset();
    set_alu(1, 0, 32'hDEAD); tick(); set_alu(0, 0, 0);
    checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL drop_ready: got %0b expected 1", alu_ready_o); end
    for (int i = 0; i < 3; i++) begin
      checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 5'd0, 32'd0}) begin
        errors++; $display("FAIL drop_no_write: got we=%0b rd=%0d data=%0h expected 0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_alu(1, 10, 32'hC10); set_mem(1, 11, 32'hC11); tick(); set_alu(0, 0, 0); set_mem(0, 0, 0);
    checks++; if (stall_o !== (m_v[0] && m_v[1])) begin errors++; $display("FAIL mid_stall: got %0b expected %0b", stall_o, m_v[0] && m_v[1]); end
    reset = 1; tick(); reset = 0; #1;
    checks++; if ({alu_ready_o, mem_ready_o} !== 2'b11) begin errors++; $display("FAIL mid_ready: got %b expected 11", {alu_ready_o, mem_ready_o}); end
    for (int i = 0; i < 4; i++) begin
      checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b0, 5'd0, 32'd0}) begin
        errors++; $display("FAIL mid_discard: got we=%0b rd=%0d data=%0h expected 0/0/0", rf_we_o, rf_waddr_o, rf_wdata_o); end
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      set_alu($urandom_range(0, 2) != 0, $urandom_range(0, 4), $urandom);
      set_mem($urandom_range(0, 2) != 0, $urandom_range(0, 4), $urandom);
      #1;
      checks++; if ({alu_ready_o, mem_ready_o, stall_o} !== {m_ready(0), m_ready(1), m_v[0] && m_v[1]}) begin
        errors++; $display("FAIL rand_ready_stall cycle %0d: got %b expected %b", n, {alu_ready_o, mem_ready_o, stall_o}, {m_ready(0), m_ready(1), m_v[0] && m_v[1]}); end
      tick();
      checks++; if ({rf_we_o, rf_waddr_o, rf_wdata_o} !== {exp_we, exp_addr, exp_data}) begin
        errors++; $display("FAIL rand_write cycle %0d: got we=%0b rd=%0d data=%0h expected we=%0b rd=%0d data=%0h",
                           n, rf_we_o, rf_waddr_o, rf_wdata_o, exp_we, exp_addr, exp_data); end
    end
    reset = 0; set_alu(0, 0, 0); set_mem(0, 0, 0);
  endtask

  initial begin
    reset = 1; set_alu(0, 0, 0); set_mem(0, 0, 0);
    test_reset();
`ifndef WB_BYPASS_EN
    test_single_alu();
    test_same_cycle();
    test_starve();
    test_age();
`else
    test_bypass();
`endif
    test_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
